bf16_fma_issue: RTL and testbench
=================================

// Module: bf16_fma_issue
// PURPOSE
// Command front-end for the bf16_fma datapath. Buffers operand triples in a small FIFO
// (valid/ready in) and issues one operation at a time to the FMA. It pulses enable for
// one cycle, waits out the FMA register latency and captures result/fpcsr. It returns
// them on a valid/ready response channel with the command tag, and accumulates sticky
// FP exception flags.
// PARAMETERS
// DEPTH    4  command FIFO entries; power of two, >= 2
// TAG_W    4  width of the opaque command tag echoed on the response
// FMA_LAT  1  cycles from the enable-high cycle to the cycle where fma_result is valid
// PORTS
// clk            in   1      clock, all state on rising edge
// reset          in   1      synchronous, active-high
// cmd_valid      in   1      command present
// cmd_ready      out  1      FIFO can accept (= !full)
// cmd_a/b/c      in   16     bf16 operands A, B, C
// cmd_op         in   3      100 ADD, 101 MUL, 110 SUB, 111 FMADD; 000-011 illegal
// cmd_tag        in   TAG_W  echoed on rsp_tag
// fma_enable     out  1      one-cycle issue strobe to FMA
// fma_operand_a/b/c out 16   operands; held stable from issue until capture
// fma_operation  out  3      opcode to FMA
// fma_result     in   16     FMA result
// fma_fpcsr      in   4      FMA flags {NV,OF,UF,NX}
// rsp_valid      out  1      response present
// rsp_ready      in   1      consumer accepts
// rsp_result     out  16     captured result
// rsp_flags      out  4      captured flags
// rsp_tag        out  TAG_W  tag of the completed command
// fflags         out  4      sticky OR of all rsp_flags since reset/clear
// fflags_clr     in   1      clear sticky flags
// busy           out  1      FSM not IDLE or FIFO non-empty
// BEHAVIOUR
// - Reset, applied in any state, mid-op included: all outputs 0, FIFO empty, FSM IDLE,
//   fflags 0. An in-flight op is dropped and no response is produced.
// - FIFO: push on cmd_valid&&cmd_ready. wr/rd pointers have DEPTH+1 bits; wrap is
//   modulo DEPTH. Full = DEPTH entries and empty = 0 entries, both from pointer MSB
//   compare. No bypass: cmd_ready depends only on occupancy. Push and pop in the same
//   cycle are both honoured.
// - FSM IDLE: if FIFO non-empty, pop head into operand/op/tag regs and go to ISSUE.
// - FSM ISSUE (1 cycle): fma_enable=1 and operands driven. Go to WAIT with cnt=1.
//   An illegal op skips the FMA: no enable; load rsp_result=16'h7FC0 and
//   rsp_flags=4'b1000; go to RESP.
// - FSM WAIT: cnt increments each cycle. When cnt==FMA_LAT, sample fma_result and
//   fma_fpcsr into the rsp regs at that edge and go to RESP. FMA_LAT=1 means a 1-cycle
//   WAIT. fma_enable=0 throughout.
// - FSM RESP: rsp_valid=1, with result/flags/tag held stable until rsp_ready. On the
//   handshake edge: if FIFO non-empty, pop and go to ISSUE directly; else go to IDLE.
//   rsp_valid falls on the next cycle unless a new response is loaded. With rsp_ready
//   held high, issue-to-issue is FMA_LAT+2 cycles.
// - fflags next = (fflags_clr ? 0 : fflags) | (rsp handshake ? rsp_flags : 0). Flags
//   arriving in the same cycle as a clear are retained.
// - fma_operand_*/fma_operation keep their last issued value outside ISSUE/WAIT.
//   Only fma_enable qualifies them.
// - Commands complete in FIFO order; exactly one response per accepted command.
// TESTING (bench stubs FMA: registers a behavioural bf16 FMA on enable, latency FMA_LAT)
// 1 FMADD a=3F80 b=4000 c=3F00, tag 5 -> one fma_enable pulse; rsp 4020, tag 5,
//   flags 0; rsp_valid 3 cycles after accept+1.
// 2 ADD a=xxxx b=4000 c=3F80 then MUL a=4000 b=4040 c=0 back-to-back -> rsp 4040 then
//   40C0, in order, issues FMA_LAT+2 apart.
// 3 Fill DEPTH cmds with rsp_ready=0 -> cmd_ready=0 after DEPTH+1 accepts, 1 held in
//   RESP. Release rsp_ready -> all DEPTH+1 rsps drain in order and pointers wrap.
// 4 op=3'b010 tag 3 -> no fma_enable; rsp 7FC0 flags 1000. fflags=1000, then
//   fflags_clr -> fflags=0.
// 5 Stub returns fpcsr 0001 with fflags_clr asserted in the same handshake cycle ->
//   fflags=0001.
// 6 Reset asserted during WAIT -> next cycle rsp_valid=0, busy=0, cmd_ready=1, and no
//   response for the dropped cmd.

Source files
------------

// File: rtl/bf16_fma_issue.sv
// Command front-end for the bf16 FMA: buffers operand triples in a FIFO, issues one
// operation at a time, captures result/flags and returns them with the command tag.
module bf16_fma_issue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int FMA_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [15:0]      cmd_c,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             fma_enable,
  output logic [15:0]      fma_operand_a,
  output logic [15:0]      fma_operand_b,
  output logic [15:0]      fma_operand_c,
  output logic [2:0]       fma_operation,
  input  logic [15:0]      fma_result,
  input  logic [3:0]       fma_fpcsr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FMA_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic [15:0]      a_mem   [DEPTH];
  logic [15:0]      b_mem   [DEPTH];
  logic [15:0]      c_mem   [DEPTH];
  logic [2:0]       op_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             empty, full, push, pop;
  logic [15:0]      head_a, head_b, head_c;
  logic [2:0]       head_op;
  logic [TAG_W-1:0] head_tag;
  logic             en_q, ill_q;
  logic [15:0]      opa_q, opb_q, opc_q;
  logic [2:0]       opn_q;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    cnt_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [3:0]       fflags_q, fflags_d;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = !empty && ((state_q == IDLE) ||
                                ((state_q == RESP) && rsp_ready));

  assign head_a   = a_mem[rd_ptr_q[AW-1:0]];
  assign head_b   = b_mem[rd_ptr_q[AW-1:0]];
  assign head_c   = c_mem[rd_ptr_q[AW-1:0]];
  assign head_op  = op_mem[rd_ptr_q[AW-1:0]];
  assign head_tag = tag_mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q[AW-1:0]]   <= cmd_a;
      b_mem[wr_ptr_q[AW-1:0]]   <= cmd_b;
      c_mem[wr_ptr_q[AW-1:0]]   <= cmd_c;
      op_mem[wr_ptr_q[AW-1:0]]  <= cmd_op;
      tag_mem[wr_ptr_q[AW-1:0]] <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      ill_q        <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      opc_q        <= '0;
      opn_q        <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
    end else begin
      en_q <= 1'b0;
      // Illegal opcodes never reach the FMA, so its operand bus keeps the last real issue.
      if (pop) begin
        ill_q <= !head_op[2];
        tag_q <= head_tag;
        en_q  <= head_op[2];
        if (head_op[2]) begin
          opa_q <= head_a;
          opb_q <= head_b;
          opc_q <= head_c;
          opn_q <= head_op;
        end
      end
      case (state_q)
        IDLE: begin
          if (pop) state_q <= ISSUE;
        end
        ISSUE: begin
          if (ill_q) begin
            rsp_result_q <= 16'h7FC0;
            rsp_flags_q  <= 4'b1000;
            rsp_tag_q    <= tag_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q   <= CW'(1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CW'(FMA_LAT)) begin
            rsp_result_q <= fma_result;
            rsp_flags_q  <= fma_fpcsr;
            rsp_tag_q    <= tag_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= pop ? ISSUE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flags landing in the same cycle as a clear survive it.
  always_comb begin
    fflags_d = fflags_clr ? 4'b0000 : fflags_q;
    if (rsp_valid_q && rsp_ready) fflags_d = fflags_d | rsp_flags_q;
  end

  always_ff @(posedge clk) begin
    if (reset) fflags_q <= '0;
    else       fflags_q <= fflags_d;
  end

  assign fma_enable    = en_q;
  assign fma_operand_a = opa_q;
  assign fma_operand_b = opb_q;
  assign fma_operand_c = opc_q;
  assign fma_operation = opn_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_tag       = rsp_tag_q;
  assign fflags        = fflags_q;
  assign busy          = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_bf16_fma_issue.sv
// Bench for bf16_fma_issue: behavioural FMA stub, scoreboard of expected responses in
// command order, directed scenarios followed by randomized traffic.
module tb_bf16_fma_issue;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int FMA_LAT = 1;

  logic             clk, reset;
  logic             cmd_valid, cmd_ready;
  logic [15:0]      cmd_a, cmd_b, cmd_c;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic             fma_enable;
  logic [15:0]      fma_operand_a, fma_operand_b, fma_operand_c;
  logic [2:0]       fma_operation;
  logic [15:0]      fma_result;
  logic [3:0]       fma_fpcsr;
  logic             rsp_valid, rsp_ready;
  logic [15:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic [3:0]       fflags;
  logic             fflags_clr;
  logic             busy;

  int total = 0;
  int bad   = 0;

  bf16_fma_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .FMA_LAT(FMA_LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .fma_enable(fma_enable), .fma_operand_a(fma_operand_a), .fma_operand_b(fma_operand_b),
    .fma_operand_c(fma_operand_c), .fma_operation(fma_operation),
    .fma_result(fma_result), .fma_fpcsr(fma_fpcsr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // bf16 <-> real; subnormal inputs read as zero, tiny results flush to zero.
  function automatic real bf2r(input logic [15:0] h);
    logic [63:0] d;
    if (h[14:7] == 8'd0) return 0.0;
    d = {h[15], 11'(h[14:7]) + 11'd896, h[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [19:0] r2bf(input real r);
    logic [63:0] d;
    int          e;
    logic [7:0]  m;
    logic        g, st, up;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {4'b0000, d[63], 15'd0};
    e  = int'(d[62:52]) - 1023 + 127;
    m  = {1'b0, d[51:45]};
    g  = d[44];
    st = |d[43:0];
    up = g & (st | m[0]);
    m  = m + 8'(up);
    if (m[7]) begin
      m = 8'd0;
      e++;
    end
    if (e >= 255) return {4'b0101, d[63], 8'hFF, 7'd0};
    if (e <= 0)   return {4'b0011, d[63], 15'd0};
    return {3'b000, g | st, d[63], e[7:0], m[6:0]};
  endfunction

  // {flags, result} the FMA would produce; illegal opcodes get the canonical NaN + NV.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [2:0] op);
    real ra, rb, rc;
    ra = bf2r(a);
    rb = bf2r(b);
    rc = bf2r(c);
    case (op)
      3'b100:  return r2bf(rb + rc);
      3'b101:  return r2bf(ra * rb);
      3'b110:  return r2bf(rb - rc);
      3'b111:  return r2bf(ra * rb + rc);
      default: return {4'b1000, 16'h7FC0};
    endcase
  endfunction

  logic [19:0] stub_pipe [FMA_LAT];
  initial for (int i = 0; i < FMA_LAT; i++) stub_pipe[i] = 20'd0;
  always @(posedge clk) begin
    if (fma_enable)
      stub_pipe[0] <= model(fma_operand_a, fma_operand_b, fma_operand_c, fma_operation);
    for (int i = 1; i < FMA_LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
  end
  assign fma_result = stub_pipe[FMA_LAT-1][15:0];
  assign fma_fpcsr  = stub_pipe[FMA_LAT-1][19:16];

  logic [19+TAG_W:0] exp_q [$];
  logic [50:0]       iss_q [$];
  logic [19:0]       rsp_log [$];
  logic [3:0]        ff_m = 4'd0;
  longint            cyc = 0, last_en = 0, en_gap = 0;
  int                en_cnt = 0, acc_cnt = 0;

  always @(negedge clk) begin
    logic [3:0]        ffn;
    logic [19+TAG_W:0] r;
    logic [50:0]       e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      iss_q.delete();
      ff_m = 4'd0;
    end else begin
      chk("fflags", fflags, ff_m);
      ffn = fflags_clr ? 4'd0 : ff_m;
      if (fma_enable) begin
        en_cnt++;
        en_gap  = cyc - last_en;
        last_en = cyc;
        if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          e = iss_q.pop_front();
          chk("issue_operands", {fma_operation, fma_operand_a, fma_operand_b, fma_operand_c}, e);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back({rsp_flags, rsp_result});
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          r = exp_q.pop_front();
          chk("rsp_result", rsp_result, r[TAG_W +: 16]);
          chk("rsp_flags", rsp_flags, r[TAG_W+16 +: 4]);
          chk("rsp_tag", rsp_tag, r[TAG_W-1:0]);
          ffn = ffn | r[TAG_W+16 +: 4];
        end
      end
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        exp_q.push_back({model(cmd_a, cmd_b, cmd_c, cmd_op), cmd_tag});
        if (cmd_op[2]) iss_q.push_back({cmd_op, cmd_a, cmd_b, cmd_c});
      end
      ff_m = ffn;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [2:0] op, input logic [TAG_W-1:0] tag);
    logic ok;
    int   n;
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 fflags_clr = 1'b1;
    @(posedge clk); #1 fflags_clr = 1'b0;
  endtask

  function automatic logic [15:0] rnd_bf();
    return {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got=hang expected=finish");
    $fatal(1);
  end

  initial begin
    int e0, a0;
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_c = '0;
    cmd_op = '0; cmd_tag = '0; rsp_ready = 1'b1; fflags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_fma_enable", fma_enable, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_operand_a", fma_operand_a, 0);

    // 1: single FMADD, latency and one enable pulse
    @(posedge clk); #1;
    e0 = en_cnt;
    send(16'h3F80, 16'h4000, 16'h3F00, 3'b111, 4'd5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_rsp_valid_timing", rsp_valid, (k == 4));
    end
    chk("t1_result", rsp_result, 16'h4020);
    chk("t1_tag", rsp_tag, 4'd5);
    chk("t1_flags", rsp_flags, 4'd0);
    wait_idle();
    chk("t1_enable_pulses", en_cnt - e0, 1);

    // 2: back-to-back ADD then MUL
    rsp_log.delete();
    @(posedge clk); #1;
    send(16'h1234, 16'h4000, 16'h3F80, 3'b100, 4'd1);
    send(16'h4000, 16'h4040, 16'h0000, 3'b101, 4'd2);
    wait_idle();
    chk("t2_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      chk("t2_first", rsp_log[0][15:0], 16'h4040);
      chk("t2_second", rsp_log[1][15:0], 16'h40C0);
    end
    chk("t2_issue_gap", en_gap, FMA_LAT + 2);

    // 3: fill the FIFO behind a stalled response, then drain
    @(posedge clk); #1 rsp_ready = 1'b0;
    a0 = acc_cnt;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cmd_a = rnd_bf(); cmd_b = rnd_bf(); cmd_c = rnd_bf();
      cmd_op = 3'($urandom_range(4, 7)); cmd_tag = TAG_W'(i);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_accepts", acc_cnt - a0, DEPTH + 1);
    chk("t3_cmd_ready_full", cmd_ready, 0);
    chk("t3_rsp_held", rsp_valid, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();
    chk("t3_drained", exp_q.size(), 0);

    // 4: illegal opcode, then clear
    clr_pulse();
    e0 = en_cnt;
    send(16'h3F80, 16'h3F80, 16'h3F80, 3'b010, 4'd3);
    wait_idle();
    chk("t4_no_enable", en_cnt - e0, 0);
    chk("t4_rsp", rsp_log[$], {4'b1000, 16'h7FC0});
    chk("t4_fflags_set", fflags, 4'b1000);
    clr_pulse();
    @(negedge clk);
    chk("t4_fflags_cleared", fflags, 4'b0000);

    // 5: NX arrives in the same cycle as a clear of an older NV
    @(posedge clk); #1;
    send(16'h0000, 16'h0000, 16'h0000, 3'b000, 4'd9);
    wait_idle();
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(16'h3F80, 16'h3F80, 16'h3B80, 3'b100, 4'd7);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_pre_fflags", fflags, 4'b1000);
    @(posedge clk); #1 rsp_ready = 1'b1; fflags_clr = 1'b1;
    @(posedge clk); #1 fflags_clr = 1'b0;
    @(negedge clk);
    chk("t5_fflags", fflags, 4'b0001);
    chk("t5_rsp", rsp_log[$], {4'b0001, 16'h3F80});

    // 6: reset during WAIT drops the command
    @(posedge clk); #1;
    send(16'h3F80, 16'h4000, 16'h3F00, 3'b111, 4'd6);
    n = 0;
    @(negedge clk);
    while (!fma_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_enable_seen", fma_enable, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_no_rsp", rsp_valid, 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cmd_valid  = 1'($urandom);
      cmd_a      = rnd_bf(); cmd_b = rnd_bf(); cmd_c = rnd_bf();
      cmd_op     = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3))
                                               : 3'($urandom_range(4, 7));
      cmd_tag    = TAG_W'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      fflags_clr = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1; fflags_clr = 1'b0;
    wait_idle();
    chk("random_drained", exp_q.size(), 0);
    chk("random_issue_drained", iss_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
